// File: rtl/jk_pkg.sv
// Shared types and excitation helper for the j/k pattern driver.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_CLR  = 2'b01;

    // Don't-care cases are resolved to HOLD so j and k are never both high.
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
        logic [1:0] r;
        r = JK_HOLD;
        if (!q && t)
            r = JK_SET;
        else if (q && !t)
            r = JK_CLR;
        return r;
    endfunction

endpackage

// File: rtl/jk_check_pipe.sv
// Two-stage expected-bit pipeline comparing fb_in against the driven pattern;
// keeps a saturating mismatch count and a sticky mismatch flag.
module jk_check_pipe #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             exp_bit,
    input  logic             fb_in,
    output logic [CNT_W-1:0] err_count,
    output logic             mismatch
);

    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    logic s1_v, s1_b, s2_v, s2_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v      <= 1'b0;
            s1_b      <= 1'b0;
            s2_v      <= 1'b0;
            s2_b      <= 1'b0;
            err_count <= '0;
            mismatch  <= 1'b0;
        end else if (clr) begin
            s1_v      <= en;
            s1_b      <= exp_bit;
            s2_v      <= 1'b0;
            s2_b      <= 1'b0;
            err_count <= '0;
            mismatch  <= 1'b0;
        end else begin
            s1_v <= en;
            s1_b <= exp_bit;
            s2_v <= s1_v;
            s2_b <= s1_b;
            // Stage 2 lines up with fb_in two edges after its j/k were registered.
            if (s2_v && (s2_b != fb_in)) begin
                mismatch <= 1'b1;
                if (err_count != ERR_MAX)
                    err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_pattern_driver.sv
// Drives j/k so an attached JK-type FSM follows a target bit pattern (LSB first)
// and counts where its output disagreed.
//
// state | meaning
// IDLE  | waiting for start; latches pattern/len and drives bit 0 on accept
// DRIVE | registering j/k for bits 1..len-1, then HOLD
// DRAIN | waiting one cycle for the final compare
// DONE  | one-cycle done pulse (len=0 spends an extra cycle here before the pulse)
module jk_pattern_driver
    import jk_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   len,
    input  logic               fb_in,
    output logic               j,
    output logic               k,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_count,
    output logic               mismatch
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

    state_t             state;
    logic [MAX_LEN-1:0] pat_r;
    logic [CNT_W-1:0]   rem;
    logic               q_m;
    logic [CNT_W-1:0]   len_c;
    logic               accept;
    logic               push;
    logic               push_bit;

    always_comb begin
        len_c    = (len > LEN_MAX) ? LEN_MAX : len;
        accept   = (state == IDLE) && start;
        push     = 1'b0;
        push_bit = 1'b0;
        if (accept) begin
            push     = (len_c != '0);
            push_bit = pattern[0];
        end else if ((state == DRIVE) && (rem != '0)) begin
            push     = 1'b1;
            push_bit = pat_r[0];
        end
    end

    // pat_r is a shift register so the next bit to drive is always pat_r[0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pat_r <= '0;
            rem   <= '0;
            q_m   <= 1'b0;
            j     <= 1'b0;
            k     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_r <= pattern >> 1;
                        busy  <= 1'b1;
                        if (len_c == '0) begin
                            q_m   <= fb_in;
                            state <= DONE;
                        end else begin
                            {j, k} <= jk_excite(fb_in, pattern[0]);
                            q_m    <= pattern[0];
                            rem    <= len_c - 1'b1;
                            state  <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (rem != '0) begin
                        {j, k} <= jk_excite(q_m, pat_r[0]);
                        q_m    <= pat_r[0];
                        pat_r  <= pat_r >> 1;
                        rem    <= rem - 1'b1;
                    end else begin
                        {j, k} <= JK_HOLD;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    jk_check_pipe #(.CNT_W(CNT_W)) u_check (
        .clk       (clk),
        .reset     (reset),
        .clr       (accept),
        .en        (push),
        .exp_bit   (push_bit),
        .fb_in     (fb_in),
        .err_count (err_count),
        .mismatch  (mismatch)
    );

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Directed bench for jk_pattern_driver with a JK FSM model on the feedback path.
module tb_jk_pattern_driver;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        fb_in;
    logic        j, k, busy, done, mismatch;
    logic [4:0]  err_count;

    logic        use_model;
    logic        model_load;
    logic        fsm_out;
    int          n_vec;
    int          n_err;
    int          both_cnt;
    int          done_at;
    logic [1:0]  jk_log [0:40];

    jk_pattern_driver #(.MAX_LEN(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .fb_in     (fb_in),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .mismatch  (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset)
            fsm_out <= 1'b0;
        else if (model_load)
            fsm_out <= 1'b1;
        else if (j && !k)
            fsm_out <= 1'b1;
        else if (!j && k)
            fsm_out <= 1'b0;
    end

    assign fb_in = use_model ? fsm_out : 1'b0;

    always @(negedge clk)
        if (j && k) both_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a run at the next edge, logs j/k after every edge, and optionally
    // pulses start with junk inputs before edges p1/p2 (relative to E0).
    task automatic do_run(input string tag, input logic [15:0] pat, input logic [4:0] ln,
                          input int exp_done, input logic [4:0] exp_err, input logic exp_mm,
                          input int n_jk, input logic [9:0] exp_jk,
                          input int p1, input int p2);
        @(negedge clk);
        pattern = pat;
        len     = ln;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        jk_log[0] = {j, k};
        done_at   = -1;
        chk({tag, "_clr_err"}, 32'(err_count), 32'd0);
        chk({tag, "_busy0"}, 32'(busy), (ln == 5'd0) ? 32'd1 : 32'd1);
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            if (c == p1 || c == p2) begin
                start   = 1'b1;
                pattern = 16'h0000;
                len     = 5'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c <= 40) jk_log[c] = {j, k};
            if (done && done_at < 0) done_at = c;
        end
        start = 1'b0;
        chk({tag, "_done_at"}, 32'(done_at), 32'(exp_done));
        chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_mm"}, 32'(mismatch), 32'(exp_mm));
        chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
        for (int i = 0; i < n_jk; i++)
            chk($sformatf("%s_jk%0d", tag, i), 32'(jk_log[i]), 32'(exp_jk[2*i +: 2]));
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        both_cnt   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        pattern    = '0;
        len        = '0;
        use_model  = 1'b1;
        model_load = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_jk", 32'({j, k}), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_mm", 32'(mismatch), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // model from 0, 1011: 10,00,01,10 then hold
        do_run("basic", 16'b1011, 5'd4, 5, 5'd0, 1'b0, 5, 10'b00_10_01_00_10, -1, -1);

        // fb tied 0, q_m=0, 0101: 10,01,10,01,00; bits 0 and 2 miscompare
        use_model = 1'b0;
        do_run("fb0", 16'b0101, 5'd4, 5, 5'd2, 1'b1, 5, 10'b00_01_10_01_10, -1, -1);

        // model back at 0; junk starts on E2 and on the done cycle are ignored
        use_model = 1'b1;
        do_run("ignore", 16'b1011, 5'd4, 5, 5'd0, 1'b0, 5, 10'b00_10_01_00_10, 2, 6);

        @(negedge clk);
        model_load = 1'b1;
        @(negedge clk);
        model_load = 1'b0;
        chk("preset", 32'(fsm_out), 32'd1);
        do_run("q1", 16'b111, 5'd3, 4, 5'd0, 1'b0, 5, 10'b0, -1, -1);

        do_run("len0", 16'hFFFF, 5'd0, 1, 5'd0, 1'b0, 2, 10'b0, -1, -1);

        do_run("clamp", 16'hA5C3, 5'd20, 17, 5'd0, 1'b0, 0, 10'b0, -1, -1);
        chk("clamp_jk16", 32'(jk_log[16]), 32'd0);

        // async reset mid-DRIVE after two miscompares have landed
        use_model = 1'b0;
        @(negedge clk);
        pattern = 16'hFFFF;
        len     = 5'd8;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_err", 32'(err_count), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_jk", 32'({j, k}), 32'd0);
        chk("arst_busy_done", 32'({busy, done}), 32'd0);
        chk("arst_err_mm", 32'({err_count, mismatch}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold", 32'({j, k, busy, done}), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        use_model = 1'b1;
        do_run("after_rst", 16'b1011, 5'd4, 5, 5'd0, 1'b0, 5, 10'b00_10_01_00_10, -1, -1);

        chk("jk_exclusive", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
